draw_score: RTL
===============

# draw_score

Overlay stage placed directly after `draw_game_over` in the VGA pixel pipeline. It takes that stage's timing bundle and RGB and draws the current score (0–15) as two decimal digits, scaled 4×, in a fixed on-screen box. When the score changes, the digits flash in a highlight colour for a set number of frames. All timing signals are delayed to stay aligned with the RGB, so the outputs feed `hs`/`vs`/`r`/`g`/`b` or a later overlay unchanged.

## Interface
Parameters:
- `X_POS`, 11'd16, left pixel column of the score box.
- `Y_POS`, 11'd16, top pixel row of the score box.
- `FG_COLOR`, 12'hFFF, normal digit colour.
- `FLASH_COLOR`, 12'hFF0, digit colour while the flash counter is non-zero.
- `FLASH_FRAMES`, 6'd30, number of frames the flash lasts after a score change.

Ports:
- `pclk` in 1: pixel clock (65 MHz); the only clock.
- `rst` in 1: synchronous, active-high reset.
- `hcount_in`, `vcount_in` in 11: pixel counters from upstream.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in` in 1: timing from upstream.
- `rgb_in` in 12: upstream pixel colour, {r,g,b}.
- `score` in 4: current score from the apple logic.
- `hcount_out`, `vcount_out` out 11: `hcount_in`/`vcount_in` delayed 2 cycles.
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out` out 1: timing inputs delayed 2 cycles.
- `rgb_out` out 12: composited pixel.

## Operation
- Box is 64×32 px: two digit cells of 32×32 px. Each cell is an 8×8 glyph scaled ×4.
- `in_box` is true when `X_POS ≤ hcount_in < X_POS+64` and `Y_POS ≤ vcount_in < Y_POS+32`.
  - `rel_x = hcount_in − X_POS` and `rel_y = vcount_in − Y_POS`, both 11-bit.
  - Compare against the unsigned bounds, not against wrapped differences.
- Cell select is `rel_x[5]` (0 = tens, 1 = ones). Glyph column is `rel_x[4:2]`; glyph row is `rel_y[4:2]`.
- Internal 10-entry × 8-row × 8-bit digit font. Bit 7 is the leftmost pixel.
- Score latch `score_q`:
  - Loaded from `score` only at frame start (`hcount_in==0 && vcount_in==0`), so one frame never mixes two values.
  - Digits come from `score_q`: tens = (`score_q ≥ 10`), ones = `score_q` − 10·tens.
  - A tens digit of 0 is suppressed; that cell shows `rgb_in`.
- Flash counter `flash_cnt`, 6-bit, evaluated at frame start:
  - If the new `score` ≠ `score_q`, load `FLASH_FRAMES`.
  - Otherwise, if non-zero, decrement by 1. It saturates at 0.
  - Load wins over decrement when both apply.
- Pixel rule at stage 2:
  - If delayed `hblnk` or `vblnk` is high: `rgb_out` = 12'h000.
  - Else if in box, digit visible and glyph bit = 1: `FLASH_COLOR` when `flash_cnt≠0`, otherwise `FG_COLOR`.
  - Else: `rgb_in` delayed 2 cycles.
- The colour choice uses the `flash_cnt` value registered alongside stage 1, so a colour change takes effect for the whole frame.

## Timing
- Latency is exactly 2 `pclk` cycles from any input to every output; all outputs move in lockstep.
- Stage 1 registers: `in_box`, digit value, glyph row/column, delayed timing, delayed `rgb_in`.
- Stage 2 registers: font lookup, bit select, colour mux, all outputs.
- Reset values: every output, both pipeline stages, `score_q` and `flash_cnt` are 0.
  - The first valid output appears 2 cycles after `rst` deasserts.
- Reset mid-frame: outputs are 0 on the next edge. The pipeline refills and the next frame start reloads `score_q`.
  - Because `score_q` resets to 0, a non-zero `score` at the first frame start after reset triggers a flash. This is required behaviour.
- `score` may change at any cycle; it is sampled only at frame start.

## Test plan
- Reset, then `score=0`, full frame → pixel (X_POS+32+4·c, Y_POS+4·r) shows `FG_COLOR` wherever glyph '0' bit (r,c)=1. Tens cell equals `rgb_in`; outside the box equals `rgb_in`. Outputs lag inputs by 2 cycles.
- `score=13` held over 2 frames → tens cell shows '1' and ones cell shows '3'. Frame 1 uses `FLASH_COLOR`. `flash_cnt` = 29 at frame 2 start, reaching 0 after 30 frames, after which `FG_COLOR` is used.
- `score` changes 7→8 at mid-frame (vcount=300) → rest of that frame still shows '7'. The next frame shows '8' in `FLASH_COLOR`.
- Change at frame start while `flash_cnt=5` → counter reloads to 30, no decrement.
- Box pixels during `hblnk=1` or `vblnk=1` → `rgb_out`=12'h000. Box edges: hcount=X_POS−1 and X_POS+64 pass `rgb_in` through.
- Assert `rst` for 1 cycle mid-line → all outputs 0 the next cycle. Valid outputs resume 2 cycles after release. A non-zero `score` produces a flash on the next frame.

Source files
------------

// File: rtl/draw_score.sv
// rtl/draw_score.sv - two-digit 4x-scaled score overlay with change flash, 2-cycle pipeline
module draw_score #(
   parameter logic [10:0] X_POS        = 11'd16,
   parameter logic [10:0] Y_POS        = 11'd16,
   parameter logic [11:0] FG_COLOR     = 12'hFFF,
   parameter logic [11:0] FLASH_COLOR  = 12'hFF0,
   parameter logic [5:0]  FLASH_FRAMES = 6'd30
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [3:0]  score,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   // 8x8 glyphs packed row 0 in the top byte; bit 7 of each row is the leftmost pixel
   function automatic logic [7:0] glyph_row(input logic [3:0] d, input logic [2:0] r);
      logic [63:0] g;
      case (d)
         4'd0:    g = 64'h3C666E7666663C00;
         4'd1:    g = 64'h1838181818187E00;
         4'd2:    g = 64'h3C66060C18307E00;
         4'd3:    g = 64'h3C66061C06663C00;
         4'd4:    g = 64'h0C1C3C6C7E0C0C00;
         4'd5:    g = 64'h7E607C0606663C00;
         4'd6:    g = 64'h3C607C6666663C00;
         4'd7:    g = 64'h7E060C1830303000;
         4'd8:    g = 64'h3C66663C66663C00;
         4'd9:    g = 64'h3C66663E060C3800;
         default: g = 64'h0;
      endcase
      glyph_row = g[{3'd7 - r, 3'b000} +: 8];
   endfunction

   logic [3:0]  score_q, score_d;
   logic [5:0]  flash_cnt_q, flash_cnt_d;

   logic [10:0] rel_x, rel_y;
   logic        in_box, frame_start, tens, cell_visible;
   logic [3:0]  ones, cell_digit;

   logic        s1_in_box_q, s1_vis_q, s1_flash_q;
   logic [3:0]  s1_digit_q;
   logic [2:0]  s1_row_q, s1_col_q;
   logic [10:0] s1_hcount_q, s1_vcount_q;
   logic        s1_hsync_q, s1_vsync_q, s1_hblnk_q, s1_vblnk_q;
   logic [11:0] s1_rgb_q;

   logic [10:0] s2_hcount_q, s2_vcount_q;
   logic        s2_hsync_q, s2_vsync_q, s2_hblnk_q, s2_vblnk_q;
   logic [11:0] s2_rgb_q, rgb_d;
   logic [7:0]  font_bits;
   logic        pix_on;
   logic        unused_bits;

   assign rel_x       = hcount_in - X_POS;
   assign rel_y       = vcount_in - Y_POS;
   // Bounds use the raw counters with a carry bit so a box near the right/bottom edge never wraps
   assign in_box      = (hcount_in >= X_POS) && ({1'b0, hcount_in} < ({1'b0, X_POS} + 12'd64)) &&
                        (vcount_in >= Y_POS) && ({1'b0, vcount_in} < ({1'b0, Y_POS} + 12'd32));
   assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

   assign tens         = (score_q >= 4'd10);
   assign ones         = tens ? (score_q - 4'd10) : score_q;
   assign cell_digit   = rel_x[5] ? ones : {3'b000, tens};
   assign cell_visible = rel_x[5] | tens;
   assign unused_bits  = ^{rel_x[10:6], rel_x[1:0], rel_y[10:5], rel_y[1:0]};

   always_comb begin
      score_d     = score_q;
      flash_cnt_d = flash_cnt_q;
      if (frame_start) begin
         score_d = score;
         if (score != score_q) begin
            flash_cnt_d = FLASH_FRAMES;
         end else if (flash_cnt_q != 6'd0) begin
            flash_cnt_d = flash_cnt_q - 6'd1;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         score_q     <= 4'd0;
         flash_cnt_q <= 6'd0;
      end else begin
         score_q     <= score_d;
         flash_cnt_q <= flash_cnt_d;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         s1_in_box_q <= 1'b0;
         s1_vis_q    <= 1'b0;
         s1_flash_q  <= 1'b0;
         s1_digit_q  <= 4'd0;
         s1_row_q    <= 3'd0;
         s1_col_q    <= 3'd0;
         s1_hcount_q <= 11'd0;
         s1_vcount_q <= 11'd0;
         s1_hsync_q  <= 1'b0;
         s1_vsync_q  <= 1'b0;
         s1_hblnk_q  <= 1'b0;
         s1_vblnk_q  <= 1'b0;
         s1_rgb_q    <= 12'h000;
      end else begin
         s1_in_box_q <= in_box;
         s1_vis_q    <= cell_visible;
         s1_flash_q  <= (flash_cnt_q != 6'd0);
         s1_digit_q  <= cell_digit;
         s1_row_q    <= rel_y[4:2];
         s1_col_q    <= rel_x[4:2];
         s1_hcount_q <= hcount_in;
         s1_vcount_q <= vcount_in;
         s1_hsync_q  <= hsync_in;
         s1_vsync_q  <= vsync_in;
         s1_hblnk_q  <= hblnk_in;
         s1_vblnk_q  <= vblnk_in;
         s1_rgb_q    <= rgb_in;
      end
   end

   assign font_bits = glyph_row(s1_digit_q, s1_row_q);
   assign pix_on    = s1_in_box_q && s1_vis_q && font_bits[3'd7 - s1_col_q];

   always_comb begin
      rgb_d = s1_rgb_q;
      if (s1_hblnk_q || s1_vblnk_q) begin
         rgb_d = 12'h000;
      end else if (pix_on) begin
         rgb_d = s1_flash_q ? FLASH_COLOR : FG_COLOR;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         s2_hcount_q <= 11'd0;
         s2_vcount_q <= 11'd0;
         s2_hsync_q  <= 1'b0;
         s2_vsync_q  <= 1'b0;
         s2_hblnk_q  <= 1'b0;
         s2_vblnk_q  <= 1'b0;
         s2_rgb_q    <= 12'h000;
      end else begin
         s2_hcount_q <= s1_hcount_q;
         s2_vcount_q <= s1_vcount_q;
         s2_hsync_q  <= s1_hsync_q;
         s2_vsync_q  <= s1_vsync_q;
         s2_hblnk_q  <= s1_hblnk_q;
         s2_vblnk_q  <= s1_vblnk_q;
         s2_rgb_q    <= rgb_d;
      end
   end

   assign hcount_out = s2_hcount_q;
   assign vcount_out = s2_vcount_q;
   assign hsync_out  = s2_hsync_q;
   assign vsync_out  = s2_vsync_q;
   assign hblnk_out  = s2_hblnk_q;
   assign vblnk_out  = s2_vblnk_q;
   assign rgb_out    = s2_rgb_q;

endmodule
